// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - Shared AES matrix types, FSM encodings and slice helpers.
package aes_pkg;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NROWS   = 4;
  localparam int AES_WORD_W  = 32;
  localparam int AES_STATE_W = AES_NROWS * AES_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDKEY = 2'd1,
    ST_SEND   = 2'd2
  } aes_state_e;

  typedef logic [AES_NROWS-1:0][AES_WORD_W-1:0] aes_matrix_t;

  // Row k of a flat state occupies the MSB-first 32-bit slot k.
  function automatic logic [AES_WORD_W-1:0] aes_row(input logic [AES_STATE_W-1:0] st,
                                                    input int k);
    return st[AES_STATE_W-1-AES_WORD_W*k -: AES_WORD_W];
  endfunction

  function automatic logic [AES_BYTE_W-1:0] aes_byte(input logic [AES_WORD_W-1:0] w,
                                                     input int c);
    return w[AES_WORD_W-1-AES_BYTE_W*c -: AES_BYTE_W];
  endfunction
endpackage

// File: rtl/aes_row_addkey.sv
// rtl/aes_row_addkey.sv - One row of AddRoundKey: byte-wise XOR with a key word when enabled.
module aes_row_addkey
  import aes_pkg::*;
(
  input  logic                  en_in,
  input  logic [AES_WORD_W-1:0] row_in,
  input  logic [AES_WORD_W-1:0] key_in,
  output logic [AES_WORD_W-1:0] row_out
);
  always_comb begin
    row_out = row_in;
    if (en_in) begin
      for (int c = 0; c < AES_WORD_W / AES_BYTE_W; c++) begin
        row_out[AES_WORD_W-1-AES_BYTE_W*c -: AES_BYTE_W] = aes_byte(row_in, c) ^ aes_byte(key_in, c);
      end
    end
  end
endmodule

// File: rtl/matrix_unload_aes.sv
// rtl/matrix_unload_aes.sv - Captures a finished AES state, optionally adds the last round key,
// and streams it out as four row words over valid/ready.
module matrix_unload_aes
  import aes_pkg::*;
#(
  parameter bit ZEROIZE   = 1'b1,
  parameter bit ROW_ORDER = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en_in,
  input  logic                   st_valid_in,
  output logic                   st_ready_out,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   add_key_in,
  input  logic [AES_WORD_W-1:0]  key0_in,
  input  logic [AES_WORD_W-1:0]  key1_in,
  input  logic [AES_WORD_W-1:0]  key2_in,
  input  logic [AES_WORD_W-1:0]  key3_in,
  output logic                   data_valid_out,
  input  logic                   data_ready_in,
  output logic [AES_WORD_W-1:0]  data_out,
  output logic                   last_out,
  output logic                   busy_out
);
  aes_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  aes_matrix_t matrix_q, matrix_d;
  aes_matrix_t key_q, key_d;
  aes_matrix_t keyed;
  logic [1:0]  row_sel;
  logic        xfer;

  for (genvar g = 0; g < AES_NROWS; g++) begin : g_row
    aes_row_addkey u_addkey (
      .en_in   (state_q == ST_ADDKEY),
      .row_in  (matrix_q[g]),
      .key_in  (key_q[g]),
      .row_out (keyed[g])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      matrix_q <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      matrix_q <= matrix_d;
      key_q    <= key_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    matrix_d       = matrix_q;
    key_d          = key_q;
    st_ready_out   = (state_q == ST_IDLE);
    busy_out       = (state_q != ST_IDLE);
    // en_in low masks the word without disturbing idx, so it is re-presented later.
    data_valid_out = en_in && (state_q == ST_SEND);
    row_sel        = ROW_ORDER ? ~idx_q : idx_q;
    data_out       = data_valid_out ? matrix_q[row_sel] : '0;
    last_out       = data_valid_out && (idx_q == 2'd3);
    xfer           = data_valid_out && data_ready_in;

    if (en_in) begin
      case (state_q)
        ST_IDLE: begin
          if (st_valid_in) begin
            matrix_d = {aes_row(state_in, 3), aes_row(state_in, 2),
                        aes_row(state_in, 1), aes_row(state_in, 0)};
            key_d    = {key3_in, key2_in, key1_in, key0_in};
            idx_d    = 2'd0;
            state_d  = add_key_in ? ST_ADDKEY : ST_SEND;
          end
        end
        ST_ADDKEY: begin
          matrix_d = keyed;
          state_d  = ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = ST_IDLE;
              if (ZEROIZE) matrix_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_unload_aes.sv
// tb/tb_matrix_unload_aes.sv - Self-checking bench for matrix_unload_aes (both row orders).
module tb_matrix_unload_aes;
  logic         clk = 1'b0;
  logic         rst, en, st_valid, add_key, ready;
  logic [127:0] st;
  logic [31:0]  k0, k1, k2, k3;
  logic         st_ready0, dv0, last0, busy0;
  logic [31:0]  do0;
  logic         st_ready1, dv1, last1, busy1;
  logic [31:0]  do1;
  int           n_chk = 0;
  int           n_fail = 0;

  localparam logic [127:0] ST1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KFF = {128{1'b1}};

  always #5 clk = ~clk;

  matrix_unload_aes #(.ZEROIZE(1'b1), .ROW_ORDER(1'b0)) dut0 (
    .clk_in(clk), .rst_in(rst), .en_in(en), .st_valid_in(st_valid), .st_ready_out(st_ready0),
    .state_in(st), .add_key_in(add_key), .key0_in(k0), .key1_in(k1), .key2_in(k2), .key3_in(k3),
    .data_valid_out(dv0), .data_ready_in(ready), .data_out(do0), .last_out(last0), .busy_out(busy0));

  matrix_unload_aes #(.ZEROIZE(1'b1), .ROW_ORDER(1'b1)) dut1 (
    .clk_in(clk), .rst_in(rst), .en_in(en), .st_valid_in(st_valid), .st_ready_out(st_ready1),
    .state_in(st), .add_key_in(add_key), .key0_in(k0), .key1_in(k1), .key2_in(k2), .key3_in(k3),
    .data_valid_out(dv1), .data_ready_in(ready), .data_out(do1), .last_out(last1), .busy_out(busy1));

  // Reference: i-th word sent; rev sends rows 3..0. keys packed as {key0,key1,key2,key3}.
  function automatic logic [31:0] model_word(input logic [127:0] s, input logic ak,
                                             input logic [127:0] keys, input int i, input bit rev);
    int r;
    logic [31:0] w;
    r = rev ? 3 - i : i;
    w = s[127-32*r -: 32];
    if (ak) w = w ^ keys[127-32*r -: 32];
    return w;
  endfunction

  task automatic accept(input logic [127:0] s, input logic ak, input logic [127:0] keys);
    st = s; add_key = ak; {k0, k1, k2, k3} = keys; st_valid = 1'b1; en = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({dv0, last0, busy0, do0, dv1, last1, busy1, do1} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got d0 v=%b l=%b b=%b d=%h, expected all zero", dv0, last0, busy0, do0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({st_ready0, st_ready1, dv0, busy0} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b%b v=%b b=%b, expected rdy=11 v=0 b=0", st_ready0, st_ready1, dv0, busy0);
    end
  endtask

  task automatic test_plain();
    ready = 1'b1;
    accept(ST1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {1'b1, i == 3, model_word(ST1, 1'b0, '0, i, 1'b0)}) begin
        n_fail++; $display("FAIL plain_w%0d_d0: got v=%b l=%b d=%h, expected d=%h", i, dv0, last0, do0, model_word(ST1, 1'b0, '0, i, 1'b0));
      end
      n_chk++;
      if ({dv1, last1, do1} !== {1'b1, i == 3, model_word(ST1, 1'b0, '0, i, 1'b1)}) begin
        n_fail++; $display("FAIL plain_w%0d_d1: got v=%b l=%b d=%h, expected d=%h", i, dv1, last1, do1, model_word(ST1, 1'b0, '0, i, 1'b1));
      end
      @(negedge clk);
    end
    n_chk++;
    if ({st_ready0, dv0, busy0} !== 3'b100) begin
      n_fail++; $display("FAIL plain_idle: got rdy=%b v=%b b=%b, expected rdy=1 v=0 b=0", st_ready0, dv0, busy0);
    end
  endtask

  task automatic test_addkey();
    ready = 1'b1;
    accept(ST1, 1'b1, KFF);
    {k0, k1, k2, k3} = {$urandom, $urandom, $urandom, $urandom};
    n_chk++;
    if ({dv0, busy0, st_ready0} !== 3'b010) begin
      n_fail++; $display("FAIL addkey_bubble: got v=%b b=%b rdy=%b, expected v=0 b=1 rdy=0", dv0, busy0, st_ready0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {1'b1, i == 3, model_word(ST1, 1'b1, KFF, i, 1'b0)}) begin
        n_fail++; $display("FAIL addkey_w%0d_d0: got v=%b l=%b d=%h, expected d=%h", i, dv0, last0, do0, model_word(ST1, 1'b1, KFF, i, 1'b0));
      end
      n_chk++;
      if ({dv1, do1} !== {1'b1, model_word(ST1, 1'b1, KFF, i, 1'b1)}) begin
        n_fail++; $display("FAIL addkey_w%0d_d1: got v=%b d=%h, expected d=%h", i, dv1, do1, model_word(ST1, 1'b1, KFF, i, 1'b1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    accept(ST1, 1'b0, '0);
    @(negedge clk);
    ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {2'b10, model_word(ST1, 1'b0, '0, 1, 1'b0)}) begin
        n_fail++; $display("FAIL stall_c%0d: got v=%b l=%b d=%h, expected d=%h", j, dv0, last0, do0, model_word(ST1, 1'b0, '0, 1, 1'b0));
      end
      @(negedge clk);
    end
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {1'b1, i == 3, model_word(ST1, 1'b0, '0, i, 1'b0)}) begin
        n_fail++; $display("FAIL stall_resume_w%0d: got v=%b l=%b d=%h, expected d=%h", i, dv0, last0, do0, model_word(ST1, 1'b0, '0, i, 1'b0));
      end
      @(negedge clk);
    end
    n_chk++;
    if (st_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: got rdy=%b, expected 1", st_ready0);
    end
  endtask

  task automatic test_enable();
    ready = 1'b1;
    accept(ST1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      n_chk++;
      if ({dv0, last0, do0, dv1, do1} !== '0) begin
        n_fail++; $display("FAIL en_low_c%0d: got v=%b d=%h v1=%b d1=%h, expected zeros", j, dv0, do0, dv1, do1);
      end
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    for (int i = 2; i < 4; i++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {1'b1, i == 3, model_word(ST1, 1'b0, '0, i, 1'b0)}) begin
        n_fail++; $display("FAIL en_resume_w%0d: got v=%b l=%b d=%h, expected d=%h", i, dv0, last0, do0, model_word(ST1, 1'b0, '0, i, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s;
    s = {$urandom, $urandom, $urandom, $urandom};
    ready = 1'b1;
    accept(ST1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({dv0, last0, busy0, do0, dv1, do1} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got v=%b l=%b b=%b d=%h, expected zeros", dv0, last0, busy0, do0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({st_ready0, st_ready1} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b%b, expected 11", st_ready0, st_ready1);
    end
    accept(s, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({dv0, last0, do0} !== {1'b1, i == 3, model_word(s, 1'b0, '0, i, 1'b0)}) begin
        n_fail++; $display("FAIL rst_new_w%0d: got v=%b l=%b d=%h, expected d=%h", i, dv0, last0, do0, model_word(s, 1'b0, '0, i, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore();
    logic [127:0] b;
    b = {$urandom, $urandom, $urandom, $urandom};
    ready = 1'b1; en = 1'b1; add_key = 1'b0; st = ST1; st_valid = 1'b1;
    @(negedge clk);
    st = b;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({last0, do0, last1, do1} !== {i == 3, model_word(ST1, 1'b0, '0, i, 1'b0),
                                        i == 3, model_word(ST1, 1'b0, '0, i, 1'b1)}) begin
        n_fail++; $display("FAIL ignore_a_w%0d: got d0=%h d1=%h, expected %h %h", i, do0, do1,
                           model_word(ST1, 1'b0, '0, i, 1'b0), model_word(ST1, 1'b0, '0, i, 1'b1));
      end
      @(negedge clk);
    end
    n_chk++;
    if ({st_ready0, dv0} !== 2'b10) begin
      n_fail++; $display("FAIL ignore_bubble: got rdy=%b v=%b, expected rdy=1 v=0", st_ready0, dv0);
    end
    @(negedge clk);
    st_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({dv0, do0, dv1, do1} !== {1'b1, model_word(b, 1'b0, '0, i, 1'b0), 1'b1, model_word(b, 1'b0, '0, i, 1'b1)}) begin
        n_fail++; $display("FAIL ignore_b_w%0d: got d0=%h d1=%h, expected %h %h", i, do0, do1,
                           model_word(b, 1'b0, '0, i, 1'b0), model_word(b, 1'b0, '0, i, 1'b1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [127:0] s, keys;
    logic ak;
    int got0, got1, cyc;
    for (int blk = 0; blk < 12; blk++) begin
      s    = {$urandom, $urandom, $urandom, $urandom};
      keys = {$urandom, $urandom, $urandom, $urandom};
      ak   = 1'($urandom_range(0, 1));
      ready = 1'b1;
      accept(s, ak, keys);
      got0 = 0; got1 = 0; cyc = 0;
      while ((got0 < 4 || got1 < 4) && cyc < 200) begin
        en    = ($urandom_range(0, 3) != 0);
        ready = ($urandom_range(0, 2) != 0);
        #1;
        n_chk++;
        if (dv0 !== 1'b1 && do0 !== 32'h0) begin
          n_fail++; $display("FAIL rnd_idle_data: got d=%h with v=%b, expected 0", do0, dv0);
        end
        if (dv0 === 1'b1 && ready) begin
          n_chk++;
          if ({last0, do0} !== {got0 == 3, model_word(s, ak, keys, got0, 1'b0)}) begin
            n_fail++; $display("FAIL rnd_b%0d_w%0d_d0: got l=%b d=%h, expected %h", blk, got0, last0, do0, model_word(s, ak, keys, got0, 1'b0));
          end
          got0++;
        end
        if (dv1 === 1'b1 && ready) begin
          n_chk++;
          if ({last1, do1} !== {got1 == 3, model_word(s, ak, keys, got1, 1'b1)}) begin
            n_fail++; $display("FAIL rnd_b%0d_w%0d_d1: got l=%b d=%h, expected %h", blk, got1, last1, do1, model_word(s, ak, keys, got1, 1'b1));
          end
          got1++;
        end
        @(negedge clk);
        cyc++;
      end
      n_chk++;
      if (cyc >= 200) begin
        n_fail++; $display("FAIL rnd_b%0d_timeout: got %0d/%0d words, expected 4/4", blk, got0, got1);
      end
      en = 1'b1;
      #1;
      n_chk++;
      if ({st_ready0, busy0, st_ready1} !== 3'b101) begin
        n_fail++; $display("FAIL rnd_b%0d_idle: got rdy=%b b=%b, expected rdy=1 b=0", blk, st_ready0, busy0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; st_valid = 1'b0; add_key = 1'b0; ready = 1'b0;
    st = '0; k0 = '0; k1 = '0; k2 = '0; k3 = '0;
    test_reset();
    test_plain();
    test_addkey();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
